// File: rtl/jedro_1_lsu_pkg.sv
// Shared types and helpers for the jedro_1 load-store unit.
package jedro_1_lsu_pkg;

  localparam int unsigned LSU_DATA_WIDTH = 32;
  localparam int unsigned LSU_BE_WIDTH   = LSU_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'b00,
    LSU_HALF = 2'b01,
    LSU_WORD = 2'b10
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    WAIT   = 2'b10
  } lsu_state_e;

  // Byte-enable mask for an access of the given size at byte offset a.
  function automatic logic [LSU_BE_WIDTH-1:0] lsu_be(lsu_size_e size, logic [1:0] a);
    logic [LSU_BE_WIDTH-1:0] be;
    case (size)
      LSU_BYTE: be = 4'b0001 << a;
      LSU_HALF: be = 4'b0011 << a;
      LSU_WORD: be = 4'b1111;
      default:  be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/jedro_1_lsu_if.sv
// Byte-write RAM port between the LSU (master) and the data RAM (slave).
interface jedro_1_lsu_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    mem_en_o;
  logic [DATA_WIDTH/8-1:0] mem_we_o;
  logic [ADDR_WIDTH-1:0]   mem_addr_o;
  logic [DATA_WIDTH-1:0]   mem_wdata_o;
  logic [DATA_WIDTH-1:0]   mem_rdata_i;

  modport master (
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/jedro_1_load_extend.sv
// Lane select plus sign/zero extension of RAM read data for lb/lbu/lh/lhu/lw.
module jedro_1_load_extend
  import jedro_1_lsu_pkg::*;
(
  input  logic [LSU_DATA_WIDTH-1:0] rdata,
  input  logic [1:0]                a,
  input  lsu_size_e                 size,
  input  logic                      is_unsigned,
  output logic [LSU_DATA_WIDTH-1:0] data
);

  logic [LSU_DATA_WIDTH-1:0] shifted;

  // Words are always aligned, so the shifted value doubles as the word result.
  always_comb begin
    shifted = rdata >> {a, 3'b000};
    data    = shifted;
    case (size)
      LSU_BYTE: data = is_unsigned ? {24'h0, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
      LSU_HALF: data = is_unsigned ? {16'h0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
      default:  data = shifted;
    endcase
  end

endmodule

// File: rtl/jedro_1_lsu.sv
// Load-store unit: aligns stores onto RAM byte lanes and extends loads into write-back.
module jedro_1_lsu
  import jedro_1_lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,

  input  logic                      req_valid_i,
  output logic                      ready_o,
  input  logic                      req_we_i,
  input  logic [1:0]                req_size_i,
  input  logic                      req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0]     req_addr_i,
  input  logic [DATA_WIDTH-1:0]     req_wdata_i,
  input  logic [REG_ADDR_WIDTH-1:0] req_rd_i,

  jedro_1_lsu_if.master             ram_rw_io,

  output logic                      wb_valid_o,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd_o,
  output logic [DATA_WIDTH-1:0]     wb_data_o,
  output logic                      misaligned_o
);

  lsu_state_e                state_q, state_d;
  logic                      we_q, we_d;
  lsu_size_e                 size_q, size_d;
  logic                      uns_q, uns_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                      wb_valid_d;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_d;
  logic [DATA_WIDTH-1:0]     wb_data_d;
  logic                      mis_d;

  lsu_size_e                 req_size;
  logic                      req_misaligned;
  logic                      in_access;
  logic [DATA_WIDTH-1:0]     load_data;

  assign req_size       = lsu_size_e'(req_size_i);
  assign req_misaligned = ((req_size == LSU_HALF) && req_addr_i[0]) ||
                          ((req_size == LSU_WORD) && (req_addr_i[1:0] != 2'b00));

  jedro_1_load_extend u_load_extend (
    .rdata       (ram_rw_io.mem_rdata_i),
    .a           (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .data        (load_data)
  );

  // Next-state and request capture.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_o;
    wb_data_d  = wb_data_o;
    mis_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (req_misaligned) begin
            mis_d = 1'b1;
          end else begin
            we_d    = req_we_i;
            size_d  = req_size;
            uns_d   = req_unsigned_i;
            addr_d  = req_addr_i;
            wdata_d = req_wdata_i;
            rd_d    = req_rd_i;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: state_d = we_q ? IDLE : WAIT;
      WAIT: begin
        wb_valid_d = 1'b1;
        wb_rd_d    = rd_q;
        wb_data_d  = load_data;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      size_q       <= LSU_BYTE;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      wb_valid_o   <= 1'b0;
      wb_rd_o      <= '0;
      wb_data_o    <= '0;
      misaligned_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      wb_valid_o   <= wb_valid_d;
      wb_rd_o      <= wb_rd_d;
      wb_data_o    <= wb_data_d;
      misaligned_o <= mis_d;
    end
  end

  assign ready_o   = (state_q == IDLE);
  assign in_access = (state_q == ACCESS);

  // RAM strobes come from registered state only; reset masks them so no write slips through.
  assign ram_rw_io.mem_en_o    = in_access && !rst_i;
  assign ram_rw_io.mem_we_o    = (in_access && we_q && !rst_i) ? lsu_be(size_q, addr_q[1:0]) : 4'b0000;
  assign ram_rw_io.mem_addr_o  = in_access ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign ram_rw_io.mem_wdata_o = in_access ? (wdata_q << {addr_q[1:0], 3'b000}) : '0;

endmodule

// File: tb/tb_jedro_1_lsu.sv
// Scoreboard bench for jedro_1_lsu against a small byte-write RAM model.
module tb_jedro_1_lsu;
  import jedro_1_lsu_pkg::*;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_uns = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        ready_o;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        misaligned_o;

  wb_exp_t     exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          en_count = 0;
  logic [31:0] ram [0:255];

  jedro_1_lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ram_if ();

  jedro_1_lsu dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .ready_o        (ready_o),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_unsigned_i (req_uns),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .req_rd_i       (req_rd),
    .ram_rw_io      (ram_if.master),
    .wb_valid_o     (wb_valid_o),
    .wb_rd_o        (wb_rd_o),
    .wb_data_o      (wb_data_o),
    .misaligned_o   (misaligned_o)
  );

  always #5 clk = ~clk;

  // RAM model: byte-write, read data registered one cycle after the strobe.
  always @(posedge clk) begin
    if (ram_if.mem_en_o) begin
      en_count <= en_count + 1;
      for (int b = 0; b < 4; b++)
        if (ram_if.mem_we_o[b])
          ram[ram_if.mem_addr_o[9:2]][8*b +: 8] <= ram_if.mem_wdata_o[8*b +: 8];
      ram_if.mem_rdata_i <= ram[ram_if.mem_addr_o[9:2]];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return in the cycle after it was accepted.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    int g = 0;
    req_we = we; req_size = size; req_uns = uns;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    req_valid = 1'b1;
    while (!ready_o && g < 10) begin
      step();
      g++;
    end
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready_o); end
    n_cmp++;
    if ({ram_if.mem_en_o, ram_if.mem_we_o, ram_if.mem_addr_o, ram_if.mem_wdata_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_mem got en=%b we=%b addr=%h wdata=%h want all 0", ram_if.mem_en_o,
               ram_if.mem_we_o, ram_if.mem_addr_o, ram_if.mem_wdata_o);
    end
    n_cmp++;
    if ({wb_valid_o, wb_rd_o, wb_data_o, misaligned_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_wb got v=%b rd=%0d data=%h mis=%b want all 0", wb_valid_o, wb_rd_o,
               wb_data_o, misaligned_o);
    end
    rst = 1'b0;
    step();
    // Preload word 0x100 through the store path.
    issue(1'b1, LSU_WORD, 1'b0, 32'h100, 32'hFF0F807F, 5'd0);
    n_cmp++;
    if (ram_if.mem_we_o !== 4'b1111) begin n_fail++; $display("FAIL sw_we got %b want 1111", ram_if.mem_we_o); end
    step();
  endtask

  task automatic test_loads(input logic [1:0] sz[4], input logic us[4], input logic [31:0] ad[4],
                            input logic [4:0] rdv[4], input logic [31:0] ex[4]);
    wb_exp_t e;
    int cyc;
    for (int i = 0; i < 4; i++) begin
      e.rd = rdv[i];
      e.data = ex[i];
      exp_q.push_back(e);
      issue(1'b0, sz[i], us[i], ad[i], 32'h0, rdv[i]);
      if (i == 0) begin
        n_cmp++;
        if (ready_o !== 1'b0 || ram_if.mem_en_o !== 1'b1 || ram_if.mem_we_o !== 4'b0000 ||
            ram_if.mem_addr_o !== 32'h100) begin
          n_fail++;
          $display("FAIL load_access got ready=%b en=%b we=%b addr=%h want 0 1 0000 00000100",
                   ready_o, ram_if.mem_en_o, ram_if.mem_we_o, ram_if.mem_addr_o);
        end
      end
      cyc = 1;
      while (!wb_valid_o && cyc < 8) begin
        step();
        cyc++;
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      n_cmp++;
      if (wb_valid_o !== 1'b1 || cyc != 3) begin
        n_fail++;
        $display("FAIL load_latency[%h] got valid=%b cycle=%0d want 1 at 3", ad[i], wb_valid_o, cyc);
      end
      n_cmp++;
      if (wb_data_o !== e.data) begin
        n_fail++;
        $display("FAIL load_data[%h] got %h want %h", ad[i], wb_data_o, e.data);
      end
      n_cmp++;
      if (wb_rd_o !== e.rd) begin
        n_fail++;
        $display("FAIL load_rd[%h] got %0d want %0d", ad[i], wb_rd_o, e.rd);
      end
    end
  endtask

  task automatic test_store();
    issue(1'b1, LSU_BYTE, 1'b0, 32'h101, 32'h000000AB, 5'd0);
    n_cmp++;
    if (ram_if.mem_we_o !== 4'b0010 || ram_if.mem_wdata_o !== 32'h0000AB00 ||
        ram_if.mem_addr_o !== 32'h100) begin
      n_fail++;
      $display("FAIL sb_lanes got we=%b wdata=%h addr=%h want 0010 0000ab00 00000100",
               ram_if.mem_we_o, ram_if.mem_wdata_o, ram_if.mem_addr_o);
    end
    step();
    n_cmp++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL sb_ready got %b want 1", ready_o); end
    issue(1'b1, LSU_HALF, 1'b0, 32'h102, 32'h0000BEEF, 5'd0);
    n_cmp++;
    if (ram_if.mem_we_o !== 4'b1100 || ram_if.mem_wdata_o !== 32'hBEEF0000) begin
      n_fail++;
      $display("FAIL sh_lanes got we=%b wdata=%h want 1100 beef0000", ram_if.mem_we_o, ram_if.mem_wdata_o);
    end
    step();
    test_loads('{LSU_WORD, LSU_BYTE, LSU_HALF, LSU_BYTE}, '{1'b0, 1'b1, 1'b1, 1'b0},
               '{32'h100, 32'h101, 32'h102, 32'h100}, '{5'd7, 5'd8, 5'd9, 5'd10},
               '{32'hBEEFAB7F, 32'h000000AB, 32'h0000BEEF, 32'h0000007F});
  endtask

  task automatic test_misaligned();
    int e0 = en_count;
    int wb_seen = 0;
    req_we = 1'b0; req_size = LSU_WORD; req_uns = 1'b0; req_addr = 32'h102; req_rd = 5'd3;
    req_valid = 1'b1;
    step();
    n_cmp++;
    if (misaligned_o !== 1'b1 || ready_o !== 1'b1 || ram_if.mem_en_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_lw got mis=%b ready=%b en=%b want 1 1 0", misaligned_o, ready_o, ram_if.mem_en_o);
    end
    wb_seen += int'(wb_valid_o);
    req_size = LSU_HALF; req_addr = 32'h101;
    step();
    n_cmp++;
    if (misaligned_o !== 1'b1 || ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL mis_lh got mis=%b ready=%b want 1 1", misaligned_o, ready_o);
    end
    wb_seen += int'(wb_valid_o);
    req_valid = 1'b0;
    step();
    n_cmp++;
    if (misaligned_o !== 1'b0) begin n_fail++; $display("FAIL mis_pulse got %b want 0", misaligned_o); end
    wb_seen += int'(wb_valid_o);
    step();
    n_cmp++;
    if (en_count != e0 || wb_seen != 0) begin
      n_fail++;
      $display("FAIL mis_no_access got accesses=%0d wb=%0d want 0 0", en_count - e0, wb_seen);
    end
  endtask

  task automatic test_reset_mid();
    int wb_seen = 0;
    issue(1'b0, LSU_WORD, 1'b0, 32'h100, 32'h0, 5'd9);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if ({wb_valid_o, wb_rd_o, wb_data_o, misaligned_o, ram_if.mem_en_o, ram_if.mem_we_o} !== '0 ||
        ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_wait got v=%b rd=%0d data=%h mis=%b en=%b ready=%b want 0 0 0 0 0 1",
               wb_valid_o, wb_rd_o, wb_data_o, misaligned_o, ram_if.mem_en_o, ready_o);
    end
    for (int i = 0; i < 4; i++) begin
      wb_seen += int'(wb_valid_o);
      step();
    end
    n_cmp++;
    if (wb_seen != 0) begin n_fail++; $display("FAIL rst_drop got wb=%0d want 0", wb_seen); end
    issue(1'b1, LSU_WORD, 1'b0, 32'h100, 32'h12345678, 5'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    n_cmp++;
    if (ram[8'h40] !== 32'hBEEFAB7F) begin
      n_fail++;
      $display("FAIL rst_store got ram=%h want beefab7f", ram[8'h40]);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  sz[3] = '{LSU_BYTE, LSU_BYTE, LSU_BYTE};
    logic        we[3] = '{1'b0, 1'b1, 1'b0};
    logic        us[3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] wd[3] = '{32'h0, 32'h11, 32'h0};
    logic [4:0]  rdv[3] = '{5'd5, 5'd0, 5'd6};
    int          acc[3] = '{-100, -100, -100};
    int          t = 0;
    int          e0 = en_count;
    int          g;
    logic        accepted;
    wb_exp_t     e;
    e.rd = 5'd5; e.data = 32'h0000007F; exp_q.push_back(e);
    e.rd = 5'd6; e.data = 32'h00000011; exp_q.push_back(e);
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_we = we[i]; req_size = sz[i]; req_uns = us[i];
      req_addr = 32'h100; req_wdata = wd[i]; req_rd = rdv[i];
      accepted = 1'b0;
      g = 0;
      while (!accepted && g < 10) begin
        accepted = ready_o;
        if (accepted) acc[i] = t;
        step();
        t++;
        g++;
        if (wb_valid_o) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
          n_cmp++;
          if (wb_data_o !== e.data || wb_rd_o !== e.rd) begin
            n_fail++;
            $display("FAIL b2b_wb got rd=%0d data=%h want rd=%0d data=%h", wb_rd_o, wb_data_o, e.rd, e.data);
          end
        end
      end
    end
    req_valid = 1'b0;
    g = 0;
    while (!wb_valid_o && g < 8) begin
      step();
      g++;
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    n_cmp++;
    if (wb_valid_o !== 1'b1 || wb_data_o !== e.data || wb_rd_o !== e.rd) begin
      n_fail++;
      $display("FAIL b2b_last got v=%b rd=%0d data=%h want 1 rd=%0d data=%h",
               wb_valid_o, wb_rd_o, wb_data_o, e.rd, e.data);
    end
    n_cmp++;
    if (acc[1] - acc[0] != 3 || acc[2] - acc[0] != 5) begin
      n_fail++;
      $display("FAIL b2b_accept got %0d,%0d want 3,5", acc[1] - acc[0], acc[2] - acc[0]);
    end
    step();
    n_cmp++;
    if (en_count - e0 != 3 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_accesses got %0d pending=%0d want 3 0", en_count - e0, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_loads('{LSU_BYTE, LSU_BYTE, LSU_BYTE, LSU_BYTE}, '{1'b1, 1'b0, 1'b0, 1'b1},
               '{32'h103, 32'h103, 32'h101, 32'h100}, '{5'd1, 5'd2, 5'd3, 5'd4},
               '{32'h000000FF, 32'hFFFFFFFF, 32'hFFFFFF80, 32'h0000007F});
    test_loads('{LSU_HALF, LSU_HALF, LSU_HALF, LSU_WORD}, '{1'b1, 1'b0, 1'b0, 1'b0},
               '{32'h102, 32'h102, 32'h100, 32'h100}, '{5'd14, 5'd15, 5'd30, 5'd31},
               '{32'h0000FF0F, 32'hFFFFFF0F, 32'hFFFF807F, 32'hFF0F807F});
    test_store();
    test_misaligned();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/jedro_1_lsu.md
# jedro_1_lsu

Load-store unit for the jedro_1 core. Sits between the execute stage (which supplies an effective address, store data and access type) and the byte-write data RAM. It lane-aligns store data with byte enables, then extracts and sign- or zero-extends load data (lb/lbu/lh/lhu/lw) into a register-file write-back. A small FSM matches the RAM's one-cycle read latency and back-pressures the core through `ready_o`.

## Interface
- `DATA_WIDTH`, 32: data bus width; only 32 is supported.
- `ADDR_WIDTH`, 32: byte address width.
- `REG_ADDR_WIDTH`, 5: destination register index width.

Ports:
- `clk_i`  in  1  core clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `req_valid_i`  in  1  access request from execute.
- `ready_o`  out  1  LSU can accept a request this cycle.
- `req_we_i`  in  1  1 = store, 0 = load.
- `req_size_i`  in  2  access size: `LSU_BYTE`=00, `LSU_HALF`=01, `LSU_WORD`=10.
- `req_unsigned_i`  in  1  zero-extend the load (lbu/lhu).
- `req_addr_i`  in  ADDR_WIDTH  effective byte address.
- `req_wdata_i`  in  DATA_WIDTH  store data, right-aligned.
- `req_rd_i`  in  REG_ADDR_WIDTH  load destination register.
- `mem_en_o`  out  1  RAM access strobe.
- `mem_we_o`  out  4  byte write enables.
- `mem_addr_o`  out  ADDR_WIDTH  word-aligned address (bits [1:0] = 0).
- `mem_wdata_o`  out  DATA_WIDTH  lane-shifted store data.
- `mem_rdata_i`  in  DATA_WIDTH  RAM read data; valid one cycle after `mem_en_o`.
- `wb_valid_o`  out  1  one-cycle register write strobe.
- `wb_rd_o`  out  REG_ADDR_WIDTH  write-back register index.
- `wb_data_o`  out  DATA_WIDTH  extended load data.
- `misaligned_o`  out  1  one-cycle pulse for a rejected misaligned request.

## Operation
- FSM states:
  - `IDLE`: `ready_o` = 1.
  - `ACCESS`: RAM strobe cycle.
  - `WAIT`: read data returns.
- Acceptance happens on `req_valid_i && ready_o` at a rising edge.
- Alignment rules:
  - A half access needs `addr[0]` = 0; a word access needs `addr[1:0]` = 0.
  - A misaligned request is accepted but rejected: `misaligned_o` = 1 in the next cycle, state stays `IDLE`, and there is no RAM access and no write-back.
- A legal request is captured into internal registers and the FSM moves `IDLE` -> `ACCESS`.
- `ACCESS`:
  - `mem_en_o` = 1 and `mem_addr_o` = {addr[ADDR_WIDTH-1:2], 2'b00}.
  - Store: `mem_we_o` is byte 0001<<a, half 0011<<a, word 1111, where a = `addr[1:0]`; `mem_wdata_o` = `wdata` << (8·a). Next state `IDLE`.
  - Load: `mem_we_o` = 0000; next state `WAIT`.
- `WAIT`:
  - Select lane: byte is `rdata[8a+7:8a]`, half is `rdata[8a+15:8a]`.
  - Sign-extend when `req_unsigned_i` = 0, otherwise zero-extend; word passes through.
  - Register the result into `wb_data_o` and `wb_rd_o`, pulse `wb_valid_o`, next state `IDLE`.
- `rd` = 0 is still written back with `wb_valid_o` = 1; the register file ignores x0.
- `mem_en_o` and `mem_we_o` are gated with `!rst_i`, so no RAM write occurs in a reset cycle.
- A reset in any state: next state `IDLE`, the pending load is dropped and no `wb_valid_o` is produced.
- While `ready_o` = 0, `req_*` inputs are ignored. Execute holds them stable until accepted.

## Timing
- Reset values: `ready_o` 1 (state `IDLE`); all of `mem_*_o`, `wb_valid_o`, `wb_rd_o`, `wb_data_o` and `misaligned_o` are 0.
- `mem_*_o` are decoded from registered state and request, so there is no combinational input-to-RAM path.
- `ready_o` is decoded from state only.
- Load accepted at edge of cycle A:
  - A+1: `ACCESS`, `ready_o` = 0.
  - A+2: `WAIT`, `mem_rdata_i` is sampled.
  - A+3: `wb_valid_o` = 1 and `ready_o` = 1, so a new request may be accepted in A+3.
  - Throughput is one load per 3 cycles.
- Store accepted at A: RAM write in A+1, `ready_o` = 1 again in A+2; one store per 2 cycles.
- Misaligned request accepted at A: `misaligned_o` = 1 in A+1 only, with `ready_o` still 1. Back-to-back misaligned requests give consecutive pulses.
- `wb_valid_o` and `misaligned_o` are single-cycle pulses. `wb_data_o` holds its value until the next load completes.

## Structure
- Package `jedro_1_lsu_pkg` holds:
  - the `lsu_size_e` enum (`LSU_BYTE`, `LSU_HALF`, `LSU_WORD`);
  - the `lsu_state_e` enum (`IDLE`, `ACCESS`, `WAIT`);
  - the function `lsu_be(size, a)` returning the 4-bit enable mask.
- One sub-module: `jedro_1_load_extend`, combinational lane select plus sign/zero extension (inputs `rdata`, `a`, `size`, `unsigned`). It is shared with the formal checks.
- The FSM and request registers sit in `jedro_1_lsu`. It connects to the RAM through the existing `ram_rw_io` MASTER modport in `jedro_1_top`.

## Test plan
- Preload word 0x100 = 0xFF0F807F. lbu 0x103 -> `wb_data_o` 0x000000FF; lb 0x103 -> 0xFFFFFFFF; lb 0x101 -> 0xFFFFFF80; lbu 0x100 -> 0x0000007F. Each `wb_valid_o` lands exactly 3 cycles after acceptance.
- Same word: lhu 0x102 -> 0x0000FF0F; lh 0x102 -> 0xFFFFFF0F; lh 0x100 -> 0xFFFF807F; lw 0x100 -> 0xFF0F807F. Use rd = 14, 15, 30, 31 and check `wb_rd_o`.
- Store path:
  - sb 0xAB to 0x101 -> `mem_we_o` 0010, `mem_wdata_o` 0x0000AB00, `mem_addr_o` 0x100.
  - sh 0xBEEF to 0x102 -> `mem_we_o` 1100, `mem_wdata_o` 0xBEEF0000.
  - A following lw 0x100 -> 0xBEEFAB7F.
- Misaligned requests: lw 0x102 and lh 0x101 -> `misaligned_o` pulses in A+1 with `mem_en_o` never 1, `wb_valid_o` 0 and `ready_o` held 1.
- Reset asserted for one cycle in `WAIT` of lw 0x100 -> no `wb_valid_o`, state `IDLE`, all outputs 0 on the next cycle. A store with reset asserted during `ACCESS` -> RAM contents unchanged.
- Back-to-back: `req_valid_i` held with lb, sb, lbu -> acceptances at cycles 0, 3, 5. Requests presented while `ready_o` = 0 cause no extra accesses.
